// File: rtl/ad9866_emu.sv
// ad9866_emu: cycle-level emulation of the AD9866 nibble-serial RX/TX interface.
module ad9866_emu #(
  parameter bit LOOPBACK = 1'b0,
  parameter bit RAMP = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] rx_sample,
  input  logic        rx_sample_valid,
  output logic        rx_sample_ready,
  output logic [11:0] tx_sample,
  output logic        tx_sample_valid,
  output logic [5:0]  pga_gain,
  output logic        rx_underrun,
  output logic        tx_frame_err,
  output logic [5:0]  hw_rx_data,
  output logic        hw_rx_sync,
  output logic        hw_rx_clock,
  input  logic [5:0]  hw_tx_data,
  input  logic        hw_tx_sync,
  input  logic        hw_rx_gain,
  input  logic        hw_not_reset,
  input  logic        hw_tx_not_quiet
);
  logic        rst, lb, ext, pending;
  logic [1:0]  ph;
  logic [5:0]  ms;
  logic [11:0] held, ramp, nxt_held;
  always_comb begin
    rst = reset || !hw_not_reset;
    lb = LOOPBACK && hw_tx_not_quiet;
    ext = !RAMP && !lb;
    rx_sample_ready = (ph == 2'd3) && ext;
    // a new sample is latched at the end of ph3 so the following ph0 can emit its MS nibble
    nxt_held = (ph != 2'd3) ? held :
               lb ? tx_sample :
               RAMP ? ramp + 12'd1 :
               rx_sample_valid ? rx_sample : held;
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      ph <= 2'd0;
      hw_rx_clock <= 1'b0;
      hw_rx_data <= 6'd0;
      hw_rx_sync <= 1'b0;
      held <= 12'd0;
      ramp <= 12'd0;
      ms <= 6'd0;
      pending <= 1'b0;
      tx_sample <= 12'd0;
      tx_sample_valid <= 1'b0;
      pga_gain <= 6'd0;
      rx_underrun <= 1'b0;
      tx_frame_err <= 1'b0;
    end else begin
      ph <= ph + 2'd1;
      hw_rx_clock <= ph[0];
      held <= nxt_held;
      tx_sample_valid <= 1'b0;
      if (RAMP && ph == 2'd3) ramp <= ramp + 12'd1;
      if (rx_sample_ready && !rx_sample_valid) rx_underrun <= 1'b1;
      if (ph == 2'd3) begin
        hw_rx_data <= nxt_held[11:6];
        hw_rx_sync <= 1'b1;
      end else if (ph == 2'd1) begin
        hw_rx_data <= held[5:0];
        hw_rx_sync <= 1'b0;
      end
      if (!hw_tx_not_quiet) pending <= 1'b0;
      // odd phases end mid-nibble on the FPGA side, so tx data is stable here
      if (ph[0]) begin
        if (hw_tx_not_quiet && hw_tx_sync) begin
          ms <= hw_tx_data;
          pending <= 1'b1;
        end else if (hw_tx_not_quiet && pending) begin
          tx_sample <= {ms, hw_tx_data};
          tx_sample_valid <= 1'b1;
          pending <= 1'b0;
        end else if (hw_tx_not_quiet) begin
          tx_frame_err <= 1'b1;
        end else if (hw_rx_gain) begin
          pga_gain <= hw_tx_data;
        end
      end
    end
  end
endmodule
